// File: rtl/spi_pkg.sv
// Shared SPI definitions: spcon bit positions, slave FSM states and the decoded mode word.
// spi_master and spi_slave both import this package.
package spi_pkg;

  localparam int SPEN_B = 0;
  localparam int CPHA_B = 1;
  localparam int CPOL_B = 2;
  localparam int LSBF_B = 3;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} slv_state_e;

  typedef struct packed {
    logic lsbf;
    logic cpol;
    logic cpha;
    logic spen;
  } spi_mode_t;

  function automatic spi_mode_t decode_spcon(input logic [3:0] ctl);
    spi_mode_t m;
    m.spen = ctl[SPEN_B];
    m.cpha = ctl[CPHA_B];
    m.cpol = ctl[CPOL_B];
    m.lsbf = ctl[LSBF_B];
    return m;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Brings sck/ssn/mosi into the clk domain and derives one-clk edge pulses
// from the synchronised sck and ssn against one further registered copy.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ssn,
  input  logic mosi,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic ssn_rise,
  output logic ssn_fall
);

  logic [SYNC_STAGES-1:0] sck_q, ssn_q, mosi_q;
  logic sck_s, ssn_s, sck_d, ssn_d;

  // ssn resets low so a select still held low when reset releases
  // does not look like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      ssn_q  <= '0;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      ssn_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      ssn_q  <= {ssn_q[SYNC_STAGES-2:0], ssn};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_s;
      ssn_d  <= ssn_s;
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign ssn_s    = ssn_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign ssn_rise =  ssn_s & ~ssn_d;
  assign ssn_fall = ~ssn_s &  ssn_d;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled sck/ssn/mosi, all four CPOL/CPHA modes, byte framing
// with back-to-back bytes while ssn stays low.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    spcon,
  input  logic [DW-1:0] data_s,
  output logic [DW-1:0] data_r_s,
  output logic          rx_done,
  output logic          busy,
  input  logic          sck,
  input  logic          ssn,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  slv_state_e    state, state_nxt;
  spi_mode_t     mode_q;
  logic [DW-1:0] tx_shift, rx_shift, rx_nxt;
  logic [CW-1:0] bit_cnt;
  logic          mosi_s, sck_rise, sck_fall, ssn_rise, ssn_fall;
  logic          lead, trail, start, stop, sample, shift, byte_done;
  logic          unused_spcon, unused_spen;

  assign unused_spcon = ^spcon[7:4];
  assign unused_spen  = mode_q.spen;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sck),
    .ssn      (ssn),
    .mosi     (mosi),
    .mosi_s   (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ssn_rise (ssn_rise),
    .ssn_fall (ssn_fall)
  );

  function automatic logic tx_bit(input logic [DW-1:0] v, input logic lsbf);
    return lsbf ? v[0] : v[DW-1];
  endfunction

  function automatic logic [DW-1:0] tx_adv(input logic [DW-1:0] v, input logic lsbf);
    return lsbf ? (v >> 1) : (v << 1);
  endfunction

  // Leading edge leaves the CPOL idle level.
  assign lead  = mode_q.cpol ? sck_fall : sck_rise;
  assign trail = mode_q.cpol ? sck_rise : sck_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ssn rising wins over a coincident sample edge.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: if (ssn_fall && spcon[SPEN_B]) begin
        state_nxt = XFER;
        start     = 1'b1;
      end
      XFER: if (ssn_rise) begin
        state_nxt = IDLE;
        stop      = 1'b1;
      end else begin
        sample = mode_q.cpha ? trail : lead;
        shift  = mode_q.cpha ? lead  : trail;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_nxt    = mode_q.lsbf ? {mosi_s, rx_shift[DW-1:1]} : {rx_shift[DW-2:0], mosi_s};
  assign byte_done = sample && (bit_cnt == CW'(DW-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      data_r_s <= '0;
      rx_done  <= 1'b0;
      miso     <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (start) begin
        mode_q   <= decode_spcon(spcon[3:0]);
        bit_cnt  <= '0;
        rx_shift <= '0;
        // CPHA=0 has no leading shift edge for bit 0, so present it now
        // and leave the first trailing edge to drive bit 1.
        if (spcon[CPHA_B]) begin
          tx_shift <= data_s;
          miso     <= 1'b0;
        end else begin
          tx_shift <= tx_adv(data_s, spcon[LSBF_B]);
          miso     <= tx_bit(data_s, spcon[LSBF_B]);
        end
      end else if (stop) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (sample) begin
        rx_shift <= rx_nxt;
        if (byte_done) begin
          bit_cnt  <= '0;
          data_r_s <= rx_nxt;
          rx_done  <= 1'b1;
          tx_shift <= data_s;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else if (shift) begin
        miso     <= tx_bit(tx_shift, mode_q.lsbf);
        tx_shift <= tx_adv(tx_shift, mode_q.lsbf);
      end
    end
  end

  assign busy    = (state == XFER);
  assign miso_oe = (state == XFER);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as SPI master at pin level and checks
// received bytes, returned miso bits, framing, abort, SPEN=0 and async reset.
module tb_spi_slave;

  localparam int H = 8;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] spcon, data_s, data_r_s;
  logic       rx_done, busy, sck, ssn, mosi, miso, miso_oe;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int oe_cyc = 0;
  logic [7:0] rx_log [0:63];

  spi_slave #(.DW(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spcon(spcon), .data_s(data_s), .data_r_s(data_r_s),
    .rx_done(rx_done), .busy(busy), .sck(sck), .ssn(ssn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_done) begin
      rx_log[done_cnt[5:0]] <= data_r_s;
      done_cnt <= done_cnt + 1;
    end
    if (busy)    busy_cyc <= busy_cyc + 1;
    if (miso_oe) oe_cyc   <= oe_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master shifts tx MSB-first on the wire and collects miso MSB-first.
  task automatic xfer(input logic cpol, input logic cpha, input logic [7:0] tx,
                      input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        wait_clk(H);
        sck = ~cpol;
        rx[i] = miso;
        wait_clk(H);
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = tx[i];
        wait_clk(H);
        sck = cpol;
        rx[i] = miso;
        wait_clk(H);
      end
    end
  endtask

  task automatic frame_start(input logic [7:0] ctl, input logic [7:0] d);
    spcon = ctl;
    data_s = d;
    sck = ctl[2];
    wait_clk(H);
    ssn = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end();
    wait_clk(H);
    ssn = 1'b1;
    wait_clk(H);
  endtask

  initial begin
    logic [7:0] rb, rb2, d_keep;
    int n0, b0, o0;

    rst_n = 1'b0; spcon = 8'h00; data_s = 8'h00;
    sck = 1'b0; ssn = 1'b1; mosi = 1'b0;
    wait_clk(4);
    chk("rst_data_r_s", 32'(data_r_s), 32'h0);
    chk("rst_rx_done", 32'(rx_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_miso_oe", 32'(miso_oe), 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // Mode 0
    n0 = done_cnt;
    frame_start(8'h01, 8'hA5);
    chk("m0_busy_active", 32'(busy), 32'h1);
    chk("m0_oe_active", 32'(miso_oe), 32'h1);
    xfer(1'b0, 1'b0, 8'h3C, 8, rb);
    frame_end();
    chk("m0_miso_byte", 32'(rb), 32'hA5);
    chk("m0_data_r_s", 32'(data_r_s), 32'h3C);
    chk("m0_rx_done_cnt", 32'(done_cnt - n0), 32'd1);
    chk("m0_busy_end", 32'(busy), 32'h0);
    chk("m0_oe_end", 32'(miso_oe), 32'h0);
    chk("m0_miso_end", 32'(miso), 32'h0);

    // Mode 3
    frame_start(8'h07, 8'h81);
    xfer(1'b1, 1'b1, 8'hFF, 8, rb);
    frame_end();
    chk("m3_miso_byte", 32'(rb), 32'h81);
    chk("m3_data_r_s", 32'(data_r_s), 32'hFF);

    // Mode 1, LSB first
    frame_start(8'h0B, 8'h01);
    xfer(1'b0, 1'b1, 8'h80, 8, rb);
    frame_end();
    chk("lsbf_first_bit", 32'(rb[7]), 32'h1);
    chk("lsbf_miso_wire", 32'(rb), 32'h80);
    chk("lsbf_data_r_s", 32'(data_r_s), 32'h01);

    // Back-to-back; data_s is only sampled at byte loads, so the second
    // byte can be staged as soon as the frame-start load has happened.
    n0 = done_cnt;
    frame_start(8'h01, 8'h11);
    data_s = 8'h22;
    xfer(1'b0, 1'b0, 8'hDE, 8, rb);
    xfer(1'b0, 1'b0, 8'hAD, 8, rb2);
    frame_end();
    chk("b2b_rx_done_cnt", 32'(done_cnt - n0), 32'd2);
    chk("b2b_rx_byte0", 32'(rx_log[n0[5:0]]), 32'hDE);
    chk("b2b_rx_byte1", 32'(rx_log[n0[5:0] + 6'd1]), 32'hAD);
    chk("b2b_miso_byte0", 32'(rb), 32'h11);
    chk("b2b_miso_byte1", 32'(rb2), 32'h22);

    // Abort after 5 bits
    n0 = done_cnt;
    d_keep = data_r_s;
    frame_start(8'h01, 8'h5A);
    xfer(1'b0, 1'b0, 8'hF0, 5, rb);
    wait_clk(H);
    ssn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_oe_off", 32'(miso_oe), 32'h0);
    chk("abort_busy_off", 32'(busy), 32'h0);
    wait_clk(2 * H);
    chk("abort_no_done", 32'(done_cnt - n0), 32'd0);
    chk("abort_data_kept", 32'(data_r_s), 32'(d_keep));
    frame_start(8'h01, 8'h5A);
    xfer(1'b0, 1'b0, 8'h96, 8, rb);
    frame_end();
    chk("post_abort_rx", 32'(data_r_s), 32'h96);
    chk("post_abort_miso", 32'(rb), 32'h5A);

    // SPEN=0: bus traffic must be ignored
    n0 = done_cnt; b0 = busy_cyc; o0 = oe_cyc;
    frame_start(8'h00, 8'hFF);
    xfer(1'b0, 1'b0, 8'hC3, 8, rb);
    frame_end();
    chk("spen0_busy", 32'(busy_cyc - b0), 32'd0);
    chk("spen0_oe", 32'(oe_cyc - o0), 32'd0);
    chk("spen0_done", 32'(done_cnt - n0), 32'd0);
    chk("spen0_data_kept", 32'(data_r_s), 32'h96);

    // Async reset mid-frame
    frame_start(8'h01, 8'hFF);
    xfer(1'b0, 1'b0, 8'hFF, 4, rb);
    chk("rstmid_busy_before", 32'(busy), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_data_r_s", 32'(data_r_s), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_oe", 32'(miso_oe), 32'h0);
    chk("rstmid_miso", 32'(miso), 32'h0);
    chk("rstmid_rx_done", 32'(rx_done), 32'h0);
    wait_clk(2);
    rst_n = 1'b1;
    // ssn still low: no fresh falling edge, so no frame may start
    n0 = done_cnt; b0 = busy_cyc;
    xfer(1'b0, 1'b0, 8'hFF, 8, rb);
    chk("rstmid_no_restart", 32'(busy_cyc - b0), 32'd0);
    chk("rstmid_no_done", 32'(done_cnt - n0), 32'd0);
    frame_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target-side block, the counterpart of the team's spi_master; connects to the master's sck/mosi/miso and one ssn line.
- Oversamples sck/ssn/mosi in the system clk domain and decodes all four CPOL/CPHA modes via spcon.
- Returns data_s on miso while capturing mosi into data_r_s; supports back-to-back bytes while ssn stays low.

Parameters:
- DW, 8, bits per transfer (byte-framed).
- SYNC_STAGES, 2, flip-flop stages on sck/ssn/mosi inputs (≥2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spcon  input  8  control: [0] SPEN, [1] CPHA, [2] CPOL, [3] LSBF (LSB first), [7:4] reserved/ignored
- data_s  input  DW  transmit byte, sampled at each byte load
- data_r_s  output  DW  last complete received byte
- rx_done  output  1  one-clk pulse per completed byte
- busy  output  1  high while a frame is active
- sck  input  1  serial clock from master
- ssn  input  1  slave select, active low
- mosi  input  1  master-out data
- miso  output  1  slave-out data
- miso_oe  output  1  miso output enable, high only during an active frame

Behaviour:
- Reset: data_r_s=0, rx_done=0, busy=0, miso=0, miso_oe=0, FSM=IDLE, bit_cnt=0, shift registers=0.
- Synchronisation: sck/ssn/mosi pass through SYNC_STAGES flops. Edges are detected on the synchronised sck against one further registered copy.
- Constraint: sck high and low phases must each be ≥ SYNC_STAGES+1 clk cycles; behaviour outside this is undefined.
- Edge roles:
  - Leading edge: transition away from CPOL idle level.
  - CPHA=0: sample on leading edge, shift on trailing edge.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- spcon is latched at frame start (IDLE->XFER); changes mid-frame are ignored.
- FSM IDLE:
  - On synced ssn falling with SPEN=1: go to XFER, busy=1, miso_oe=1, tx_shift<=data_s, bit_cnt=0.
  - If CPHA=0, miso immediately drives the first bit: MSB, or LSB if LSBF.
  - If SPEN=0, stay IDLE and ignore the bus.
- FSM XFER:
  - Each sample edge: rx_shift takes mosi (shift-left if MSB-first, shift-right if LSBF); bit_cnt++.
  - Each shift edge: miso drives the next tx bit.
  - Exception: for CPHA=0, the first trailing edge after a byte load drives bit 1, not bit 0.
- Byte completion (bit_cnt wraps DW-1 -> 0 on the sample edge):
  - data_r_s <= assembled byte; rx_done pulses one cycle.
  - Latency: SYNC_STAGES+1 clk after the pin-level sampling edge.
  - tx_shift <= data_s (next byte), so its first bit appears on the next shift edge.
- Frame end or abort (synced ssn rising in XFER), in the same cycle:
  - FSM -> IDLE, busy=0, miso_oe=0, miso=0.
  - A partial byte (bit_cnt≠0) is discarded: no rx_done, data_r_s unchanged.
- ssn rising and a sample edge detected in the same cycle: the ssn rise wins and the sample is discarded.
- SPEN cleared mid-frame: frame continues until ssn rises (SPEN latched).
- Async reset mid-frame: immediate return to reset values; the next frame requires a fresh ssn falling edge.
- Extra sck edges while in IDLE or while ssn is high: ignored.

Decomposition:
- Shared package spi_pkg:
  - spcon bit index constants (SPEN_B=0, CPHA_B=1, CPOL_B=2, LSBF_B=3).
  - Slave FSM enum {IDLE, XFER}.
  - SPI mode typedef.
  - The same constants are reused by spi_master.
- Sub-module spi_in_sync: SYNC_STAGES synchroniser for sck/ssn/mosi plus sck rise/fall and ssn fall/rise edge pulses.

Test Plan:
- Mode0 (spcon=8'h01), data_s=8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; data_r_s=8'h3C; exactly one rx_done; busy low after ssn high.
- Mode3 (spcon=8'h07), data_s=8'h81, master sends 8'hFF -> miso 1,0,0,0,0,0,0,1 changing on falling sck; data_r_s=8'hFF.
- LSBF Mode1 (spcon=8'h0B), data_s=8'h01, master sends 8'h80 (MSB-first on wire) -> first miso bit 1; data_r_s=8'h01.
- Back-to-back: ssn held low for 16 sck cycles, data_s switched 8'h11->8'h22 after first rx_done, master sends 8'hDE,8'hAD -> two rx_done pulses; data_r_s 8'hDE then 8'hAD; miso carries 8'h11 then 8'h22.
- Abort: ssn raised after 5 bits -> no rx_done, data_r_s unchanged, miso_oe=0 within SYNC_STAGES+1 clk; the next full frame is received correctly.
- SPEN=0 (spcon=8'h00) with full bus traffic -> busy, miso_oe, rx_done stay 0. Async rst_n pulse mid-frame -> all outputs return to 0.
